// File: rtl/game_control_gen.sv
// rtl/game_control_gen.sv - memory-sequence game controller with rounds, timeout and lives
module game_control_gen #(
  parameter int N_KEYS     = 4,
  parameter int ROUND_W    = 4,
  parameter int MAX_ROUNDS = 16,
  parameter int TIME_W     = 4,
  parameter int TIMEOUT    = 10,
  parameter int LIVES      = 1,
  parameter int LIVES_W    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enter,
  input  logic                tick,
  input  logic [N_KEYS-1:0]   key,
  input  logic [N_KEYS-1:0]   seq_data,
  output logic [ROUND_W-1:0]  seq_addr,
  output logic [N_KEYS-1:0]   led,
  output logic [ROUND_W-1:0]  round,
  output logic [TIME_W-1:0]   time_cnt,
  output logic [LIVES_W-1:0]  lives_left,
  output logic [2:0]          state_o,
  output logic                done,
  output logic                win
);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_SETUP      = 3'd1,
    S_PLAY_FPGA  = 3'd2,
    S_PLAY_USER  = 3'd3,
    S_CHECK      = 3'd4,
    S_NEXT_ROUND = 3'd5,
    S_RESULT     = 3'd6,
    S_RETRY      = 3'd7
  } state_t;

  // round counter is one bit wider so MAX_ROUNDS == 2^ROUND_W is representable
  localparam logic [ROUND_W:0]   MAX_R      = (ROUND_W+1)'(MAX_ROUNDS);
  localparam logic [ROUND_W:0]   ROUND_ONE  = (ROUND_W+1)'(1);
  localparam logic [ROUND_W-1:0] ADDR_ONE   = ROUND_W'(1);
  localparam logic [TIME_W-1:0]  TO         = TIME_W'(TIMEOUT);
  localparam logic [TIME_W-1:0]  TIME_ONE   = TIME_W'(1);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LIVES_W-1:0] LIFE_ONE   = LIVES_W'(1);

  state_t               state, state_n;
  logic [ROUND_W-1:0]   addr_q, addr_n;
  logic [ROUND_W:0]     round_q, round_n;
  logic [TIME_W-1:0]    time_q, time_n;
  logic [LIVES_W-1:0]   lives_q, lives_n;
  logic                 miss_q, miss_n;
  logic                 win_q, win_n;

  logic                 last_entry;
  logic [ROUND_W:0]     round_inc;
  logic [TIME_W-1:0]    time_inc;
  logic                 key_ends_turn;

  assign last_entry = ({1'b0, addr_q} >= round_q);
  assign round_inc  = (round_q < MAX_R) ? round_q + ROUND_ONE : round_q;
  assign time_inc   = (time_q < TO) ? time_q + TIME_ONE : time_q;

  // state and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_INIT;
      addr_q  <= '0;
      round_q <= '0;
      time_q  <= '0;
      lives_q <= LIVES_INIT;
      miss_q  <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state   <= state_n;
      addr_q  <= addr_n;
      round_q <= round_n;
      time_q  <= time_n;
      lives_q <= lives_n;
      miss_q  <= miss_n;
      win_q   <= win_n;
    end
  end

  // next-state and datapath updates; a key that ends the turn masks a same-cycle tick
  always_comb begin
    state_n       = state;
    addr_n        = addr_q;
    round_n       = round_q;
    time_n        = time_q;
    lives_n       = lives_q;
    miss_n        = miss_q;
    win_n         = win_q;
    key_ends_turn = 1'b0;
    case (state)
      S_INIT: begin
        addr_n  = '0;
        round_n = '0;
        time_n  = '0;
        miss_n  = 1'b0;
        win_n   = 1'b0;
        lives_n = LIVES_INIT;
        state_n = S_SETUP;
      end
      S_SETUP: begin
        if (enter) begin
          addr_n  = '0;
          state_n = S_PLAY_FPGA;
        end
      end
      S_PLAY_FPGA: begin
        if (tick) begin
          if (last_entry) begin
            addr_n  = '0;
            time_n  = '0;
            state_n = S_PLAY_USER;
          end else begin
            addr_n = addr_q + ADDR_ONE;
          end
        end
      end
      S_PLAY_USER: begin
        if (key != '0) begin
          if (key != seq_data) begin
            miss_n        = 1'b1;
            key_ends_turn = 1'b1;
          end else if (last_entry) begin
            miss_n        = 1'b0;
            key_ends_turn = 1'b1;
          end else begin
            addr_n = addr_q + ADDR_ONE;
          end
        end
        if (tick && !key_ends_turn) begin
          time_n = time_inc;
          if (time_inc == TO) begin
            miss_n        = 1'b1;
            key_ends_turn = 1'b1;
          end
        end
        if (key_ends_turn) begin
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!miss_q) begin
          state_n = S_NEXT_ROUND;
        end else if (lives_q > LIFE_ONE) begin
          lives_n = lives_q - LIFE_ONE;
          state_n = S_RETRY;
        end else begin
          lives_n = '0;
          win_n   = 1'b0;
          state_n = S_RESULT;
        end
      end
      S_NEXT_ROUND: begin
        round_n = round_inc;
        if (round_inc == MAX_R) begin
          win_n   = 1'b1;
          state_n = S_RESULT;
        end else begin
          addr_n  = '0;
          time_n  = '0;
          state_n = S_PLAY_FPGA;
        end
      end
      S_RETRY: begin
        addr_n  = '0;
        time_n  = '0;
        state_n = S_PLAY_FPGA;
      end
      S_RESULT: begin
        if (!enter) begin
          state_n = S_INIT;
        end
      end
      default: state_n = S_INIT;
    endcase
  end

  assign seq_addr   = addr_q;
  assign round      = round_q[ROUND_W] ? '1 : round_q[ROUND_W-1:0];
  assign time_cnt   = time_q;
  assign lives_left = lives_q;
  assign state_o    = state;
  assign done       = (state == S_RESULT);
  assign win        = win_q;
  assign led        = (state == S_PLAY_FPGA) ? seq_data : '0;

endmodule

// File: tb/tb_game_control_gen.sv
// tb/tb_game_control_gen.sv - bench for game_control_gen
module tb_game_control_gen;

  localparam int MAXR = 3;
  localparam int TOUT = 3;
  localparam int NLIV = 2;

  localparam int P_INIT = 0, P_SETUP = 1, P_FPGA = 2, P_USER = 3;
  localparam int P_CHECK = 4, P_NEXT = 5, P_RESULT = 6, P_RETRY = 7;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] key = 4'b0;
  logic [3:0] seq_data;
  logic [3:0] seq_addr;
  logic [3:0] led;
  logic [3:0] round;
  logic [3:0] time_cnt;
  logic [1:0] lives_left;
  logic [2:0] state_o;
  logic       done;
  logic       win;

  logic [3:0] rom [16];

  int total = 0;
  int bad = 0;

  int m_st, m_idx, m_round, m_time, m_lives;
  bit m_miss, m_win;

  game_control_gen #(
    .N_KEYS(4), .ROUND_W(4), .MAX_ROUNDS(MAXR), .TIME_W(4),
    .TIMEOUT(TOUT), .LIVES(NLIV), .LIVES_W(2)
  ) dut (
    .clock(clock), .reset(reset), .enter(enter), .tick(tick), .key(key),
    .seq_data(seq_data), .seq_addr(seq_addr), .led(led), .round(round),
    .time_cnt(time_cnt), .lives_left(lives_left), .state_o(state_o),
    .done(done), .win(win)
  );

  always #5 clock = ~clock;

  assign seq_data = rom[seq_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = P_INIT; m_idx = 0; m_round = 0; m_time = 0;
    m_lives = NLIV; m_miss = 0; m_win = 0;
  endtask

  // game rules applied to one clock edge
  task automatic model_clock(input bit e, input bit t, input logic [3:0] k);
    bit turn_over;
    case (m_st)
      P_INIT: begin
        model_reset();
        m_st = P_SETUP;
      end
      P_SETUP: if (e) begin m_st = P_FPGA; m_idx = 0; end
      P_FPGA: if (t) begin
        if (m_idx < m_round) m_idx++;
        else begin m_st = P_USER; m_idx = 0; m_time = 0; end
      end
      P_USER: begin
        turn_over = 0;
        if (k != 0) begin
          if (k != rom[m_idx]) begin m_miss = 1; turn_over = 1; end
          else if (m_idx == m_round) begin m_miss = 0; turn_over = 1; end
          else m_idx++;
        end
        if (t && !turn_over) begin
          if (m_time < TOUT) m_time++;
          if (m_time == TOUT) begin m_miss = 1; turn_over = 1; end
        end
        if (turn_over) m_st = P_CHECK;
      end
      P_CHECK: begin
        if (!m_miss) m_st = P_NEXT;
        else begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin m_win = 0; m_st = P_RESULT; end
          else m_st = P_RETRY;
        end
      end
      P_NEXT: begin
        if (m_round < MAXR) m_round++;
        if (m_round == MAXR) begin m_win = 1; m_st = P_RESULT; end
        else begin m_st = P_FPGA; m_idx = 0; m_time = 0; end
      end
      P_RETRY: begin m_st = P_FPGA; m_idx = 0; m_time = 0; end
      default: if (!e) m_st = P_INIT;
    endcase
  endtask

  task automatic compare_all();
    chk("state", state_o, m_st);
    chk("seq_addr", seq_addr, m_idx);
    chk("round", round, m_round);
    chk("time_cnt", time_cnt, m_time);
    chk("lives_left", lives_left, m_lives);
    chk("done", done, (m_st == P_RESULT));
    chk("win", win, m_win);
    chk("led", led, (m_st == P_FPGA) ? rom[m_idx] : 4'b0);
  endtask

  task automatic step(input bit e, input bit t, input logic [3:0] k);
    enter = e; tick = t; key = k;
    @(posedge clock);
    model_clock(e, t, k);
    #1;
    compare_all();
    tick = 1'b0; key = 4'b0;
  endtask

  // asynchronous assertion checked before any clock edge, release after one edge
  task automatic do_reset();
    reset = 1'b0;
    #2;
    model_reset();
    chk("rst_state", state_o, 0);
    chk("rst_round", round, 0);
    chk("rst_lives", lives_left, NLIV);
    chk("rst_led", led, 0);
    chk("rst_done", done, 0);
    compare_all();
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b1;
  endtask

  task automatic fpga_phase();
    for (int i = 0; i <= m_round; i++) begin
      chk("fpga_led", led, rom[i]);
      step(1, 1, 4'b0);
    end
  endtask

  task automatic user_correct();
    for (int i = 0; i <= m_round; i++) step(1, 0, rom[i]);
  endtask

  task automatic start_game();
    step(1, 0, 4'b0);
    step(1, 0, 4'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'b0;
    rom[0] = 4'b0001; rom[1] = 4'b0100; rom[2] = 4'b0010;
    #1;
    do_reset();

    // perfect game
    start_game();
    for (int r = 0; r < MAXR; r++) begin
      fpga_phase();
      user_correct();
      step(1, 0, 4'b0);
      step(1, 0, 4'b0);
    end
    chk("s1_state", state_o, 6);
    chk("s1_done", done, 1);
    chk("s1_win", win, 1);
    chk("s1_round", round, 3);
    chk("s1_lives", lives_left, 2);
    step(1, 0, 4'b0);
    chk("s1_hold", state_o, 6);
    step(0, 0, 4'b0);
    chk("s1_exit", state_o, 0);

    // wrong key in round 1
    do_reset();
    start_game();
    fpga_phase(); user_correct(); step(1, 0, 4'b0); step(1, 0, 4'b0);
    fpga_phase();
    step(1, 0, rom[0]);
    step(1, 0, 4'b1000);
    chk("s2_check", state_o, 4);
    step(1, 0, 4'b0);
    chk("s2_retry", state_o, 7);
    chk("s2_lives", lives_left, 1);
    step(1, 0, 4'b0);
    chk("s2_replay", state_o, 2);
    chk("s2_round", round, 1);
    fpga_phase();

    // double timeout
    do_reset();
    start_game();
    step(1, 1, 4'b0);
    for (int i = 0; i < TOUT; i++) step(1, 1, 4'b0);
    chk("s3_time", time_cnt, 3);
    chk("s3_check", state_o, 4);
    step(1, 0, 4'b0);
    chk("s3_retry", state_o, 7);
    step(1, 0, 4'b0);
    step(1, 1, 4'b0);
    for (int i = 0; i < TOUT; i++) step(1, 1, 4'b0);
    step(1, 0, 4'b0);
    chk("s3_result", state_o, 6);
    chk("s3_win", win, 0);
    chk("s3_lives", lives_left, 0);
    chk("s3_round", round, 0);

    // final key with the timeout tick
    do_reset();
    start_game();
    step(1, 1, 4'b0);
    step(1, 1, 4'b0);
    step(1, 1, 4'b0);
    step(1, 1, rom[0]);
    chk("s4_check", state_o, 4);
    chk("s4_time", time_cnt, 2);
    step(1, 0, 4'b0);
    chk("s4_next", state_o, 5);
    step(1, 0, 4'b0);
    chk("s4_round", round, 1);
    chk("s4_fpga", state_o, 2);

    // ignored keys and multi-hot key
    do_reset();
    step(0, 0, 4'b0001);
    step(0, 1, 4'b0001);
    chk("s5_setup", state_o, 1);
    step(1, 0, 4'b0);
    step(1, 0, 4'b1000);
    chk("s5_fpga_addr", seq_addr, 0);
    step(1, 1, 4'b0);
    step(1, 0, 4'b0011);
    chk("s5_miss", state_o, 4);
    step(1, 0, 4'b0);
    chk("s5_retry_lives", lives_left, 1);

    // reset mid-turn then restart
    do_reset();
    start_game();
    fpga_phase(); user_correct(); step(1, 0, 4'b0); step(1, 0, 4'b0);
    fpga_phase();
    step(1, 1, rom[0]);
    chk("s6_user", state_o, 3);
    do_reset();
    start_game();
    chk("s6_restart_state", state_o, 2);
    chk("s6_restart_round", round, 0);

    // randomized play
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        bit e, t;
        int r;
        logic [3:0] k;
        e = ($urandom_range(0, 3) != 0);
        t = ($urandom_range(0, 2) == 0);
        r = $urandom_range(0, 9);
        if (r < 4) k = rom[m_idx[3:0]];
        else if (r == 4) k = 4'($urandom);
        else k = 4'b0;
        step(e, t, k);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
